// File: rtl/frame_defs.sv
// Shared frame-buffer definitions for the DDR2 fill and pixel-read paths:
// geometry defaults, command encodings and address-field placement.
package frame_defs;

    localparam logic [5:0] FRAME_BASE_DEF  = 6'd1;
    localparam int         LINE_BURSTS_DEF = 100;
    localparam int         LINES_DEF       = 600;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int X_W = 7;
    localparam int Y_W = 10;

    localparam int ADDR_W        = 31;
    localparam int ADDR_CMD_LSB  = 28;
    localparam int ADDR_BASE_LSB = 19;
    localparam int ADDR_Y_LSB    = 9;
    localparam int ADDR_X_LSB    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA2 = 2'd2
    } fill_state_t;

    // Packs a command word; the two low bits select 8-pixel burst alignment.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [2:0]     cmd,
        input logic [5:0]     base,
        input logic [Y_W-1:0] y,
        input logic [X_W-1:0] x
    );
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_CMD_LSB  +: 3]   = cmd;
        a[ADDR_BASE_LSB +: 6]   = base;
        a[ADDR_Y_LSB    +: Y_W] = y;
        a[ADDR_X_LSB    +: X_W] = x;
        return a;
    endfunction

endpackage

// File: rtl/frame_filler_if.sv
// DDR2 controller write-side FIFO bundle: address/command FIFO and
// write-data FIFO with their full flags.
interface frame_filler_if;
   logic         af_full;
   logic         wdf_full;
   logic         af_wr_en;
   logic [30:0]  af_addr_din;
   logic         wdf_wr_en;
   logic [127:0] wdf_din;
   logic [15:0]  wdf_mask_din;

   modport master (
      input  af_full, wdf_full,
      output af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din
   );

   modport slave (
      output af_full, wdf_full,
      input  af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din
   );
endinterface

// File: rtl/frame_filler.sv
// Fills a whole DDR2 frame buffer with one colour, one 256-bit burst
// (one address push, two data beats) per 8 pixels, x-fastest.
module frame_filler
   import frame_defs::*;
#(
   parameter logic [5:0] FRAME_BASE  = FRAME_BASE_DEF,
   parameter int         LINE_BURSTS = LINE_BURSTS_DEF,
   parameter int         LINES       = LINES_DEF
) (
   input  logic          cpu_clk_g,
   input  logic          rst,
   input  logic          start,
   input  logic [23:0]   color,
   output logic          ready,
   output logic          done,
   frame_filler_if.master ddr
);

   localparam logic [X_W-1:0] X_LAST = X_W'(LINE_BURSTS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(LINES - 1);

   fill_state_t    state_reg, state_next;
   logic [X_W-1:0] x_reg, x_next;
   logic [Y_W-1:0] y_reg, y_next;
   logic [23:0]    color_reg, color_next;
   logic           done_reg, done_next;
   logic           af_push, wdf_push, idle;

   always_ff @(posedge cpu_clk_g) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         color_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         color_reg <= color_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      color_next = color_reg;
      done_next  = 1'b0;
      af_push    = 1'b0;
      wdf_push   = 1'b0;
      idle       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            idle = 1'b1;
            if (start) begin
               color_next = color;
               x_next     = '0;
               y_next     = '0;
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            // Address and first beat go together so a burst is never split.
            if (!ddr.af_full && !ddr.wdf_full) begin
               af_push    = 1'b1;
               wdf_push   = 1'b1;
               state_next = ST_DATA2;
            end
         end
         ST_DATA2: begin
            if (!ddr.wdf_full) begin
               wdf_push = 1'b1;
               if (x_reg == X_LAST && y_reg == Y_LAST) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = ST_ADDR;
                  if (x_reg == X_LAST) begin
                     x_next = '0;
                     y_next = y_reg + 1'b1;
                  end else begin
                     x_next = x_reg + 1'b1;
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Reset masks the outputs immediately so nothing leaks during the reset cycle.
   assign ready        = idle | rst;
   assign done         = done_reg & ~rst;
   assign ddr.af_wr_en  = af_push & ~rst;
   assign ddr.wdf_wr_en = wdf_push & ~rst;
   assign ddr.af_addr_din  = pack_addr(CMD_WRITE, FRAME_BASE, y_reg, x_reg);
   assign ddr.wdf_mask_din = 16'h0000;

   for (genvar gi = 0; gi < 4; gi++) begin : g_pixel_lane
      assign ddr.wdf_din[gi*32 +: 32] = {8'h00, color_reg};
   end

endmodule

// File: tb/tb_frame_filler.sv
// Randomised scoreboard bench for frame_filler on a reduced frame geometry.
module tb_frame_filler;

   localparam logic [5:0] FB = 6'd1;
   localparam int LB = 5;
   localparam int LN = 4;
   localparam int NB = LB * LN;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] color;
   logic        ready;
   logic        done;

   frame_filler_if ddr ();

   frame_filler #(.FRAME_BASE(FB), .LINE_BURSTS(LB), .LINES(LN)) dut (
      .cpu_clk_g (clk),
      .rst       (rst),
      .start     (start),
      .color     (color),
      .ready     (ready),
      .done      (done),
      .ddr       (ddr)
   );

   always #5 clk = ~clk;

   logic [30:0]  addr_q[$];
   logic [127:0] data_q[$];
   int checks = 0;
   int errors = 0;
   int af_count, wdf_count, pending_beats, done_count;
   longint cycle = 0;
   longint first_push_cycle, done_cycle;
   bit done_seen, capture_first;
   logic [30:0]  first_addr, line1_addr;
   logic [127:0] first_data;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event, expected none (or timeout)", name);
   endtask

   // Reference: every burst of the frame in raster order, x fastest.
   task automatic load_frame(input logic [23:0] c);
      addr_q.delete();
      data_q.delete();
      for (int y = 0; y < LN; y++)
         for (int x = 0; x < LB; x++) begin
            addr_q.push_back(31'(int'(FB) * 524288 + y * 512 + x * 4));
            data_q.push_back({4{8'h00, c}});
            data_q.push_back({4{8'h00, c}});
         end
      af_count = 0;
      wdf_count = 0;
      pending_beats = 0;
      done_count = 0;
      done_seen = 1'b0;
      capture_first = 1'b1;
   endtask

   always @(negedge clk) begin
      cycle++;
      if (ddr.af_wr_en) begin
         check("af_push_while_af_full", ddr.af_full, 1'b0);
         check("af_push_while_wdf_full", ddr.wdf_full, 1'b0);
         check("addr_with_first_beat", ddr.wdf_wr_en, 1'b1);
         check("burst_order_addr", pending_beats, 0);
         if (capture_first) begin
            first_addr = ddr.af_addr_din;
            first_data = ddr.wdf_din;
            first_push_cycle = cycle;
            capture_first = 1'b0;
         end
         if (af_count == LB) line1_addr = ddr.af_addr_din;
         if (addr_q.size() == 0) fail("unexpected_addr_push");
         else check("addr", ddr.af_addr_din, addr_q.pop_front());
         af_count++;
         pending_beats = 1;
      end else if (ddr.wdf_wr_en) begin
         check("burst_order_beat2", pending_beats, 1);
         pending_beats = 0;
      end
      if (ddr.wdf_wr_en) begin
         check("wdf_push_while_full", ddr.wdf_full, 1'b0);
         check("mask", ddr.wdf_mask_din, 16'h0000);
         if (data_q.size() == 0) fail("unexpected_data_push");
         else check("data", ddr.wdf_din, data_q.pop_front());
         wdf_count++;
      end
      if (done) begin
         check("ready_with_done", ready, 1'b1);
         check("addr_q_empty_at_done", addr_q.size(), 0);
         check("data_q_empty_at_done", data_q.size(), 0);
         done_cycle = cycle;
         done_seen = 1'b1;
         done_count++;
      end
   end

   task automatic pulse_start(input logic [23:0] c);
      color = c;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && !done_seen; c++) begin
         @(posedge clk); #1;
      end
      if (!done_seen) fail("done_timeout");
   endtask

   task automatic frame_totals(input string tag);
      check({tag, "_af_count"}, af_count, NB);
      check({tag, "_wdf_count"}, wdf_count, 2 * NB);
      check({tag, "_done_count"}, done_count, 1);
   endtask

   logic [23:0] col_b;

   initial begin
      rst = 1'b1; start = 1'b0; color = '0;
      ddr.af_full = 1'b0; ddr.wdf_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", ready, 1'b1);
      check("reset_done", done, 1'b0);
      check("reset_af_wr_en", ddr.af_wr_en, 1'b0);
      check("reset_wdf_wr_en", ddr.wdf_wr_en, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Unstalled frame: latency, first address, first data, line wrap.
      load_frame(24'h123456);
      pulse_start(24'h123456);
      wait_done(4 * NB + 20);
      check("first_addr", first_addr, 31'h0008_0000);
      check("first_data", first_data, {4{32'h0012_3456}});
      check("line1_addr", line1_addr, 31'h0008_0200);
      check("done_latency", done_cycle - first_push_cycle, 2 * NB);
      frame_totals("plain");
      check("ready_after_done", ready, 1'b1);
      check("done_one_cycle", done, 1'b0);

      // Random 30% stalls with an ignored mid-frame start.
      col_b = 24'($urandom);
      load_frame(col_b);
      pulse_start(col_b);
      for (int c = 0; c < 4000 && !done_seen; c++) begin
         ddr.af_full  = ($urandom_range(99) < 30);
         ddr.wdf_full = ($urandom_range(99) < 30);
         start = (c == 7);
         color = (c == 7) ? 24'hFFFFFF : col_b;
         @(posedge clk); #1;
      end
      start = 1'b0;
      ddr.af_full = 1'b0; ddr.wdf_full = 1'b0;
      if (!done_seen) fail("stall_frame_timeout");
      frame_totals("stall");
      @(posedge clk); #1;

      // Hold wdf_full in DATA2 for ten cycles.
      load_frame(24'hA5C3E1);
      pulse_start(24'hA5C3E1);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         ddr.wdf_full = 1'b1;
         #2;
         check("hold_wdf_wr_en", ddr.wdf_wr_en, 1'b0);
         check("hold_af_wr_en", ddr.af_wr_en, 1'b0);
         @(posedge clk); #1;
      end
      ddr.wdf_full = 1'b0;
      #2;
      check("release_one_beat", {ddr.af_wr_en, ddr.wdf_wr_en}, 2'b01);
      @(posedge clk); #1;
      check("release_next_addr", ddr.af_wr_en, 1'b1);
      wait_done(4 * NB + 20);
      frame_totals("hold");
      @(posedge clk); #1;

      // Reset in DATA2 abandons the burst; a new start restarts at x=0,y=0.
      load_frame(24'h0F0F0F);
      pulse_start(24'h0F0F0F);
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      check("rst_af_wr_en", ddr.af_wr_en, 1'b0);
      check("rst_wdf_wr_en", ddr.wdf_wr_en, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_ready", ready, 1'b1);
      check("post_rst_enables", {ddr.af_wr_en, ddr.wdf_wr_en}, 2'b00);
      check("post_rst_done", done, 1'b0);
      load_frame(24'h00FF00);
      @(posedge clk); #1;
      pulse_start(24'h00FF00);
      wait_done(4 * NB + 20);
      check("restart_first_addr", first_addr, 31'h0008_0000);
      frame_totals("restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_filler.md
FRAME_FILLER -- requirements
Module: frame_filler

Interface
REQ-001 Parameter FRAME_BASE, default 6'd1; DDR2 frame-buffer page, placed in address bits [24:19].
REQ-002 Parameter LINE_BURSTS, default 100; 8-pixel bursts per line (800 px).
REQ-003 Parameter LINES, default 600; lines per frame.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 cpu_clk_g  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to fill the whole frame with color.
REQ-008 color  input  24  fill pixel {R,G,B}; sampled on an accepted start.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 done  output  1  one-cycle pulse after the final data beat is accepted.
REQ-011 af_full  input  1  DDR2 address FIFO full.
REQ-012 wdf_full  input  1  DDR2 write-data FIFO full.
REQ-013 af_wr_en  output  1  address/command push.
REQ-014 af_addr_din  output  31  {3'b000 write cmd, 3'b000, FRAME_BASE, y[9:0], x[6:0], 2'b00}.
REQ-015 wdf_wr_en  output  1  write-data push.
REQ-016 wdf_din  output  128  four copies of {8'h00, latched color}.
REQ-017 wdf_mask_din  output  16  constant 16'h0000; all bytes written.

Function
REQ-018 FSM states: IDLE, ADDR (address plus first data beat), DATA2 (second data beat).
REQ-019 IDLE: ready=1; start=1 latches color, clears x and y to 0, and moves to ADDR.
REQ-020 start outside IDLE is ignored; a new color takes effect only on the next accepted start.
REQ-021 ADDR: af_wr_en and wdf_wr_en both = !af_full && !wdf_full, issued in the same cycle; when both are asserted, the FSM moves to DATA2; otherwise it holds with no pushes.
REQ-022 DATA2: wdf_wr_en = !wdf_full and af_wr_en = 0; when wdf_wr_en is asserted, the burst is complete.
REQ-023 Burst complete with x==LINE_BURSTS-1 and y==LINES-1: go to IDLE and assert done for exactly that cycle.
REQ-024 Burst complete otherwise: go to ADDR; if x==LINE_BURSTS-1, set x to 0 and increment y; else increment x.
REQ-025 Each burst is 256 bits: 1 address push and exactly 2 data pushes, in order; the address push is never separated from its first beat.
REQ-026 A frame is LINE_BURSTS*LINES = 60000 address pushes and 120000 data pushes; addresses run x-fastest, no repeats or gaps.
REQ-027 Counters: x is 7 bits, y is 10 bits, neither wraps beyond its bound; af_addr_din is driven from the registered x and y.
REQ-028 af_full or wdf_full may toggle in any cycle; stall costs no beats and causes no duplicates.
REQ-029 Outputs af_wr_en, wdf_wr_en, done, and ready are pure functions of state and the full flags, with no combinational path from start.

Reset
REQ-030 rst=1 forces IDLE regardless of state, including mid-burst.
REQ-031 During reset: x=0, y=0, latched color=0, ready=1, done=0, af_wr_en=0, wdf_wr_en=0.
REQ-032 A partially written burst is abandoned on reset; the DDR2 FIFOs are reset by their owner in the same cycle.

Structure
REQ-033 Shared package `frame_defs` holds FRAME_BASE, LINE_BURSTS, LINES, the DDR2 command encodings (WRITE=3'b000, READ=3'b001), and the address-packing field positions, shared with the pixel-reading path.
REQ-034 Single flat module; no sub-module is required; the FSM and counters are inline.

Verification
REQ-035 Reset, then start with color=24'h12_34_56 and both full flags low -> first af_addr_din=31'h0008_0000, wdf_din=128'h0012_3456 repeated x4, and done exactly 120000 cycles after the first push.
REQ-036 Full frame with random af_full/wdf_full stalls at 30% -> 60000 af pushes, 120000 wdf pushes, the address sequence strictly x-fastest, and no push while the matching full flag is high.
REQ-037 Hold wdf_full=1 in DATA2 for 10 cycles -> wdf_wr_en stays 0, state is retained, and exactly one beat is pushed on release.
REQ-038 Address after x=99, y=0 burst -> next address has x=0, y=1 (31'h0008_0200); after the final burst x=99, y=599 -> done=1, ready=1.
REQ-039 Pulse start with color=24'hFFFFFF mid-frame -> ignored; wdf_din keeps the original color.
REQ-040 Assert rst during DATA2 -> next cycle IDLE with all enables 0; a subsequent start begins again at x=0, y=0.
